// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//   Serves the multicycle CPU's instruction and data ports from one
//   single-ported array of 32-bit words, one access per cycle. Each port
//   remembers the last word it was served and re-reads only when its address
//   moves or that word is overwritten. Data writes use byte strobes and always
//   win arbitration.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          synchronous reset, active low
//   instr_read   instruction read request (level)
//   instr_addr   instruction byte address
//   instr_out    registered instruction word
//   instr_valid  instr_out holds the word at the current instr_addr
//   data_read    data read request (level)
//   data_write   byte-lane write strobes, [0] = bits 7:0, nonzero = write
//   data_addr    data byte address
//   data_in      write data
//   data_out     registered data word
//   data_valid   data_out holds the word at the current data_addr
//   mem_err      sticky flag: out-of-range access seen since reset
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        mem_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_IF, GNT_DR} gnt_e;

  logic [31:0] mem [WORDS];

  // Per-port tracker: full word address (bits 31:2) so out-of-range addresses
  // never alias an in-range word.
  logic [29:0] if_wa_q, dr_wa_q;
  logic        if_tag_q, dr_tag_q;

  gnt_e        gnt_q, gnt_d;
  logic [29:0] gnt_wa_q;
  logic        rd_oor_q;
  logic [31:0] rd_word_q;

  logic [31:0] instr_out_q, data_out_q;
  logic        instr_valid_q, data_valid_q;
  logic        mem_err_q;

  logic [29:0] instr_wa, data_wa;
  logic        if_need, dr_need;
  logic [31:0] acc_addr;
  logic [ADDR_W-3:0] acc_idx;
  logic        acc_oor;

  // Byte-offset bits carry no meaning for word accesses.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{instr_addr[1:0], data_addr[1:0]};

  assign instr_wa = instr_addr[31:2];
  assign data_wa  = data_addr[31:2];

  assign if_need = instr_read && (!if_tag_q || (if_wa_q != instr_wa));
  assign dr_need = data_read  && (!dr_tag_q || (dr_wa_q != data_wa));

  // Arbitration: write > instruction fetch > data read.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_d    = GNT_NONE;
    acc_addr = '0;
    if (data_write != 4'b0000) begin
      gnt_d    = GNT_WR;
      acc_addr = data_addr;
    end else if (if_need) begin
      gnt_d    = GNT_IF;
      acc_addr = instr_addr;
    end else if (dr_need) begin
      gnt_d    = GNT_DR;
      acc_addr = data_addr;
    end
  end

  assign acc_idx = acc_addr[ADDR_W-1:2];
  assign acc_oor = |acc_addr[31:ADDR_W];

  // NOTE: the array and its read register have no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (gnt_d == GNT_WR && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (data_write[b]) mem[acc_idx][8*b +: 8] <= data_in[8*b +: 8];
      end
    end else if (gnt_d == GNT_IF || gnt_d == GNT_DR) begin
      rd_word_q <= mem[acc_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q         <= GNT_NONE;
      gnt_wa_q      <= '0;
      rd_oor_q      <= 1'b0;
      if_wa_q       <= '0;
      dr_wa_q       <= '0;
      if_tag_q      <= 1'b0;
      dr_tag_q      <= 1'b0;
      instr_out_q   <= '0;
      data_out_q    <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      gnt_wa_q <= acc_addr[31:2];
      rd_oor_q <= acc_oor;

      if (gnt_d != GNT_NONE && acc_oor) mem_err_q <= 1'b1;

      // Second stage of a read: publish only if the port still wants the same
      // word and no write has invalidated it in between.
      if (gnt_q == GNT_IF && if_tag_q && if_wa_q == gnt_wa_q && instr_wa == gnt_wa_q) begin
        instr_out_q   <= rd_oor_q ? 32'h0 : rd_word_q;
        instr_valid_q <= 1'b1;
      end
      if (gnt_q == GNT_DR && dr_tag_q && dr_wa_q == gnt_wa_q && data_wa == gnt_wa_q) begin
        data_out_q   <= rd_oor_q ? 32'h0 : rd_word_q;
        data_valid_q <= 1'b1;
      end

      // First stage: claim the word so the port does not re-request it.
      if (gnt_d == GNT_IF) begin
        if_wa_q       <= instr_wa;
        if_tag_q      <= 1'b1;
        instr_valid_q <= 1'b0;
      end
      if (gnt_d == GNT_DR) begin
        dr_wa_q      <= data_wa;
        dr_tag_q     <= 1'b1;
        data_valid_q <= 1'b0;
      end

      // Write-through coherence: a write to a tracked word forces a re-read.
      if (gnt_d == GNT_WR && !acc_oor) begin
        if (if_wa_q == acc_addr[31:2]) if_tag_q <= 1'b0;
        if (dr_wa_q == acc_addr[31:2]) dr_tag_q <= 1'b0;
      end
    end
  end

  assign instr_out   = instr_out_q;
  assign data_out    = data_out_q;
  assign instr_valid = instr_valid_q && if_tag_q && (if_wa_q == instr_wa);
  assign data_valid  = data_valid_q  && dr_tag_q && (dr_wa_q == data_wa);
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Directed bench for cpu_mem_responder: preloads words through the data
//   write port, then walks reset, read latency, arbitration, byte strobes,
//   write invalidation, stale-result discard and out-of-range handling.
// -----------------------------------------------------------------------------
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        data_read;
  logic [3:0]  data_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  cpu_mem_responder #(.ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_read  (instr_read),
    .instr_addr  (instr_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    data_addr  = a;
    data_write = s;
    data_in    = d;
    step(1);
    data_write = 4'b0000;
  endtask

  initial begin
    rst        = 1'b0;
    instr_read = 1'b0;
    instr_addr = '0;
    data_read  = 1'b0;
    data_write = 4'b0000;
    data_addr  = '0;
    data_in    = '0;
    step(2);
    rst = 1'b1;
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data_valid",  {31'b0, data_valid},  32'd0);
    check("rst_mem_err",     {31'b0, mem_err},     32'd0);
    check("rst_instr_out",   instr_out, 32'h0);
    check("rst_data_out",    data_out,  32'h0);

    // Preload
    wr(32'h00, 4'hf, 32'h0000_0013);
    wr(32'h04, 4'hf, 32'h0050_0093);
    wr(32'h08, 4'hf, 32'h00A0_0113);
    wr(32'h10, 4'hf, 32'hCAFE_F00D);
    wr(32'h20, 4'hf, 32'h1122_3344);

    // 1: reset in the middle of a data read
    data_addr = 32'h10;
    data_read = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    check("t1_data_out_rst",   data_out, 32'h0);
    check("t1_data_valid_rst", {31'b0, data_valid},  32'd0);
    check("t1_instr_valid",    {31'b0, instr_valid}, 32'd0);
    rst = 1'b1;
    step(1);
    check("t1_lat1_valid", {31'b0, data_valid}, 32'd0);
    step(1);
    check("t1_data_valid", {31'b0, data_valid}, 32'd1);
    check("t1_data_out",   data_out, 32'hCAFE_F00D);
    data_read = 1'b0;

    // 2: instruction fetch latency
    instr_read = 1'b1;
    instr_addr = 32'h0;
    step(2);
    check("t2_word0", instr_out, 32'h0000_0013);
    instr_addr = 32'h4;
    step(1);
    check("t2_valid_lat1", {31'b0, instr_valid}, 32'd0);
    step(1);
    check("t2_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_out",   instr_out, 32'h0050_0093);

    // 3: both ports move in the same cycle; instruction served first
    instr_addr = 32'h08;
    data_addr  = 32'h20;
    data_read  = 1'b1;
    step(2);
    check("t3_instr_valid", {31'b0, instr_valid}, 32'd1);
    check("t3_instr_out",   instr_out, 32'h00A0_0113);
    check("t3_data_pend",   {31'b0, data_valid}, 32'd0);
    step(1);
    check("t3_data_valid", {31'b0, data_valid}, 32'd1);
    check("t3_data_out",   data_out, 32'h1122_3344);

    // 4: strobed write of the lower two lanes
    wr(32'h20, 4'b0011, 32'hAABB_CCDD);
    check("t4_valid_drop", {31'b0, data_valid}, 32'd0);
    step(2);
    check("t4_data_valid", {31'b0, data_valid}, 32'd1);
    check("t4_data_out",   data_out, 32'h1122_CCDD);
    data_read = 1'b0;

    // 5: write to the instruction port's tracked word
    wr(32'h08, 4'hf, 32'hDEAD_BEEF);
    check("t5_valid_drop", {31'b0, instr_valid}, 32'd0);
    step(2);
    check("t5_valid", {31'b0, instr_valid}, 32'd1);
    check("t5_out",   instr_out, 32'hDEAD_BEEF);

    // Same-cycle write and read of one word: read returns the new data
    instr_addr = 32'h04;
    wr(32'h04, 4'hf, 32'h1234_5678);
    check("wr_rd_pend", {31'b0, instr_valid}, 32'd0);
    step(2);
    check("wr_rd_out", instr_out, 32'h1234_5678);

    // Stale result discarded when the address moves mid-read
    instr_addr = 32'h00;
    step(1);
    instr_addr = 32'h10;
    step(1);
    check("stale_valid", {31'b0, instr_valid}, 32'd0);
    check("stale_out_held", instr_out, 32'h1234_5678);
    step(1);
    check("stale_new_out", instr_out, 32'hCAFE_F00D);

    // Request low: output and valid hold
    instr_read = 1'b0;
    step(3);
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_out",   instr_out, 32'hCAFE_F00D);

    // 6: out-of-range read, then write; array word 0 must be intact
    data_addr = 32'h0001_0000;
    data_read = 1'b1;
    step(2);
    check("t6_oor_out",   data_out, 32'h0);
    check("t6_oor_valid", {31'b0, data_valid}, 32'd1);
    check("t6_mem_err",   {31'b0, mem_err},    32'd1);
    wr(32'h0001_0000, 4'hf, 32'hFFFF_FFFF);
    data_addr = 32'h0;
    step(2);
    check("t6_word0_intact", data_out, 32'h0000_0013);
    check("t6_mem_err_sticky", {31'b0, mem_err}, 32'd1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("t6_mem_err_rst", {31'b0, mem_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
